// File: rtl/sensor_sample_logger.sv
// Single-channel ADC sample logger: channel filter, offset subtraction with
// zero saturation, decimation, and a circular store with snapshot or ring modes.
module sensor_sample_logger #(
  parameter int DATA_W    = 12,
  parameter int CHAN_W    = 5,
  parameter int CHANNEL   = 17,
  parameter int OFFSET    = 3431,
  parameter int DECIM     = 100000,
  parameter int DEPTH     = 32,
  parameter int ADDR_W    = 5,
  parameter int HIGH_MARK = 30
) (
  input  logic              clock_in,
  input  logic              reset_n,
  input  logic              mode,
  input  logic              sample_valid,
  input  logic [CHAN_W-1:0] sample_channel,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              rd_req,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   level,
  output logic              draining,
  output logic [15:0]       dropped
);

  localparam int LVL_W = ADDR_W + 1;
  localparam int CNT_W = $clog2(DECIM);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DECIM - 1);
  localparam logic [CHAN_W-1:0] CHAN_SEL = CHAN_W'(CHANNEL);
  localparam logic [DATA_W-1:0] OFF      = DATA_W'(OFFSET);
  localparam logic [LVL_W-1:0]  DEPTH_L  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0]  HM_L     = LVL_W'(HIGH_MARK);

  typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;

  state_t              state, state_next;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
  logic [LVL_W-1:0]    level_q, level_next;
  logic [CNT_W-1:0]    dec_cnt;
  logic [DATA_W-1:0]   latest;
  logic                latest_ok;
  logic                mode_q, mode_prev;

  logic capture, tick, flush, ring, full, empty;
  logic wr_req, wr_ok, pop_ok, overwrite;

  // Read handshake: rd_req is a one-cycle request; an accepted pop answers
  // with rd_valid high for exactly one cycle, qualifying rd_data. There is no
  // back-pressure; a request against an empty or non-draining store is dropped.
  always_comb begin
    capture   = sample_valid && (sample_channel == CHAN_SEL);
    tick      = (dec_cnt == CNT_MAX);
    flush     = (mode_q != mode_prev);
    ring      = mode_q;
    full      = (level_q == DEPTH_L);
    empty     = (level_q == '0);
    wr_req    = tick && latest_ok;
    pop_ok    = !flush && rd_req && !empty && (ring || state == DRAIN);
    wr_ok     = !flush && wr_req && (ring || state == FILL);
    overwrite = wr_ok && ring && full && !pop_ok;

    level_next = level_q;
    if (flush) begin
      level_next = '0;
    end else begin
      unique case ({wr_ok, pop_ok})
        2'b10:   level_next = overwrite ? level_q : level_q + LVL_W'(1);
        2'b01:   level_next = level_q - LVL_W'(1);
        default: level_next = level_q;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    if (flush || ring) begin
      state_next = FILL;
    end else begin
      unique case (state)
        FILL:    if (level_next == HM_L) state_next = DRAIN;
        DRAIN:   if (level_next == '0)   state_next = FILL;
        default: state_next = FILL;
      endcase
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) state <= FILL;
    else          state <= state_next;
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      dec_cnt   <= '0;
      mode_q    <= 1'b0;
      mode_prev <= 1'b0;
      latest    <= '0;
      latest_ok <= 1'b0;
    end else begin
      dec_cnt   <= tick ? '0 : dec_cnt + CNT_W'(1);
      mode_q    <= mode;
      mode_prev <= mode_q;
      if (capture) begin
        latest    <= (sample_data >= OFF) ? sample_data - OFF : '0;
        latest_ok <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      dropped  <= '0;
    end else begin
      level_q  <= level_next;
      rd_valid <= pop_ok;
      if (pop_ok) rd_data <= mem[rd_ptr];
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_ok)               wr_ptr <= wr_ptr + ADDR_W'(1);
        if (pop_ok || overwrite) rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      if (overwrite && dropped != 16'hFFFF) dropped <= dropped + 16'd1;
    end
  end

  // Storage carries no reset; level and pointers define which entries are live.
  always_ff @(posedge clock_in) begin
    if (wr_ok) mem[wr_ptr] <= latest;
  end

  assign level    = level_q;
  assign draining = (state == DRAIN);

endmodule

// File: doc/sensor_sample_logger.md
Name: sensor_sample_logger

Overview:
- Parametrised successor to the board's single-channel die-temperature capture path.
- Takes the modular ADC response stream and keeps only one selected channel.
- Each accepted sample has a calibration offset subtracted, with saturation at zero.
- Samples are decimated to a programmable rate and buffered in an internal circular store, read out one entry per request.
- Two buffer modes: fill-then-drain (snapshot) and continuous ring (overwrite oldest). The logger sits between adc_qsys and the bin2bcd/seg7 display chain.

Parameters:
- DATA_W, 12, ADC sample width.
- CHAN_W, 5, ADC channel field width.
- CHANNEL, 17, channel number accepted; all others are ignored.
- OFFSET, 3431, value subtracted from every accepted sample.
- DECIM, 100000, clocks per write tick; minimum 2.
- DEPTH, 32, buffer entries; power of two.
- ADDR_W, 5, log2(DEPTH).
- HIGH_MARK, 30, level that ends FILL in snapshot mode; 1 <= HIGH_MARK <= DEPTH.

Ports:
- clock_in  input  1  system clock, 50 MHz.
- reset_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = fill-then-drain, 1 = ring.
- sample_valid  input  1  ADC response valid.
- sample_channel  input  CHAN_W  ADC response channel.
- sample_data  input  DATA_W  ADC response data.
- rd_req  input  1  single-cycle pop request, already synchronised to clock_in.
- rd_data  output  DATA_W  popped sample.
- rd_valid  output  1  one-cycle strobe qualifying rd_data.
- level  output  ADDR_W+1  current entry count, 0..DEPTH.
- draining  output  1  snapshot mode is in the DRAIN state.
- dropped  output  16  ring-mode overwrite count, saturating at 16'hFFFF.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - Pointers, level, decimation counter, latest, latest_ok, rd_data, rd_valid and dropped all go to 0.
  - FSM goes to FILL; draining=0.
- Capture:
  - Condition: sample_valid=1 and sample_channel==CHANNEL.
  - Next cycle: latest = (sample_data >= OFFSET) ? sample_data-OFFSET : 0, and latest_ok is set to 1.
  - Samples on other channels, or with valid low, leave latest unchanged.
- Decimation:
  - The counter runs 0..DECIM-1 continuously after reset.
  - tick=1 on the cycle the counter equals DECIM-1.
  - A write request is issued on tick only if latest_ok=1. No write occurs before the first matching sample.
  - If a capture and a tick occur in the same cycle, the previous latest value is written.
- Snapshot mode (mode=0), FSM states FILL and DRAIN:
  - FILL: a write request stores latest at wr_ptr and increments level. rd_req is ignored.
  - FILL -> DRAIN when level reaches HIGH_MARK. The transition is registered, so draining=1 the cycle after the write that makes level==HIGH_MARK.
  - DRAIN: write requests are discarded. rd_req with level>0 pops one entry.
  - DRAIN -> FILL when level reaches 0 after a pop.
- Ring mode (mode=1):
  - Writes are always accepted; rd_req pops whenever level>0. draining=0.
  - Write while level==DEPTH with no simultaneous pop: the oldest entry is overwritten, rd_ptr advances, level stays at DEPTH, and dropped is incremented (saturating).
  - Simultaneous write and pop: both are performed, level is unchanged, and dropped is not incremented (even when full).
- Read:
  - rd_req with level>0 gives rd_data = mem[rd_ptr] and rd_valid=1 on the next cycle. rd_ptr then advances and level decrements.
  - rd_req with level==0 is ignored: rd_valid stays 0 and rd_data holds its last value.
  - rd_valid is high for exactly one cycle per accepted pop.
- Pointers are ADDR_W bits and wrap naturally modulo DEPTH.
- Mode change:
  - mode is registered each cycle. When it differs from the registered value, the next cycle flushes the buffer: pointers and level go to 0, FSM goes to FILL, rd_valid=0.
  - latest, latest_ok, the decimation counter and dropped are preserved.
  - A write or pop coincident with the flush cycle is discarded.
- Outputs are fully registered; there are no combinational paths from inputs to outputs.

Test Plan (bench parameters: DECIM=4, DEPTH=8, ADDR_W=3, HIGH_MARK=6, OFFSET=3431, CHANNEL=17):
1. Offset and channel filter: send data 3500 on channel 17 and data 4000 on channel 3, mode=0 -> first buffered entry reads back as 69. Then send data 3000 on channel 17 -> the next entry reads 0.
2. Snapshot fill/drain: constant sample 3440, mode=0, no reads -> level climbs 1..6 on successive ticks, then draining=1 and level holds at 6 across further ticks. Six rd_req pulses -> six rd_valid strobes each with rd_data=9. level returns to 0 and draining drops; level becomes 1 at the following tick.
3. Ring overwrite: mode=1, write ramp samples 3431+0..3431+10 (11 ticks), no reads -> level=8, dropped=3. Eight pops return 3,4,...,10 in order.
4. Simultaneous full write and pop: ring mode, level=8, rd_req asserted on a tick cycle -> rd_data is the oldest entry, level stays 8, dropped unchanged.
5. Empty read and pre-sample behaviour: after reset, pulse rd_req with no samples and run 20 clocks -> rd_valid never asserts, level stays 0.
6. Async reset mid-drain, then mode toggle: assert reset_n=0 mid-drain -> level=0, draining=0 and rd_valid=0 immediately. Toggle mode while level=4 -> level=0 two cycles later, and dropped keeps its value.
